// File: rtl/service_2_countdown.sv
// mm:ss BCD countdown timer with a start/pause/resume/acknowledge pushbutton.
// TICK_DIV clk cycles make up one second of countdown.
module service_2_countdown #(
    parameter int unsigned TICK_DIV = 100000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] num_in,
    input  logic        push_c,
    output logic [15:0] remain,
    output logic        running,
    output logic        done,
    output logic        alarm
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        READY,
        RUN,
        PAUSE,
        DONE
    } state_t;

    state_t        state;
    logic [PW-1:0] presc;
    logic          tick;
    logic [15:0]   load_val;
    logic [15:0]   dec_val;

    // Clamp out-of-range digits: any digit above 9 to 9, seconds tens above 5 to 5.
    function automatic logic [15:0] sanitize(input logic [15:0] v);
        logic [3:0] mt, mo, st, so;
        mt = (v[15:12] > 4'd9) ? 4'd9 : v[15:12];
        mo = (v[11:8]  > 4'd9) ? 4'd9 : v[11:8];
        st = (v[7:4]   > 4'd5) ? 4'd5 : v[7:4];
        so = (v[3:0]   > 4'd9) ? 4'd9 : v[3:0];
        return {mt, mo, st, so};
    endfunction

    function automatic logic [15:0] bcd_dec(input logic [15:0] v);
        logic [3:0] mt, mo, st, so;
        {mt, mo, st, so} = v;
        if (v == '0) begin
            return '0;
        end
        if (so != 4'd0) begin
            so = so - 4'd1;
        end else begin
            so = 4'd9;
            if (st != 4'd0) begin
                st = st - 4'd1;
            end else begin
                st = 4'd5;
                if (mo != 4'd0) begin
                    mo = mo - 4'd1;
                end else begin
                    mo = 4'd9;
                    mt = mt - 4'd1;
                end
            end
        end
        return {mt, mo, st, so};
    endfunction

    always_comb begin
        tick     = (state == RUN) && (presc == PMAX);
        load_val = sanitize(num_in);
        dec_val  = bcd_dec(remain);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            remain  <= '0;
            presc   <= '0;
            running <= 1'b0;
            done    <= 1'b0;
            alarm   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load) begin
                remain  <= load_val;
                presc   <= '0;
                running <= 1'b0;
                alarm   <= 1'b0;
                state   <= (load_val != '0) ? READY : IDLE;
            end else begin
                case (state)
                    IDLE: ;
                    READY: begin
                        if (push_c) begin
                            state   <= RUN;
                            presc   <= '0;
                            running <= 1'b1;
                        end
                    end
                    RUN: begin
                        // Decrement wins over push_c; reaching 00:00 also discards it.
                        if (tick) begin
                            presc  <= '0;
                            remain <= dec_val;
                            if (dec_val == '0) begin
                                state   <= DONE;
                                running <= 1'b0;
                                done    <= 1'b1;
                                alarm   <= 1'b1;
                            end else if (push_c) begin
                                state   <= PAUSE;
                                running <= 1'b0;
                            end
                        end else begin
                            presc <= presc + PW'(1);
                            if (push_c) begin
                                state   <= PAUSE;
                                running <= 1'b0;
                            end
                        end
                    end
                    PAUSE: begin
                        if (push_c) begin
                            state   <= RUN;
                            running <= 1'b1;
                        end
                    end
                    DONE: begin
                        if (push_c) begin
                            state <= IDLE;
                            alarm <= 1'b0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_service_2_countdown.sv
// Self-checking bench for service_2_countdown with TICK_DIV=4: vector table with a
// scoreboard queue plus hand-written multi-cycle sequences.
module tb_service_2_countdown;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        load = 1'b0;
    logic [15:0] num_in = '0;
    logic        push_c = 1'b0;
    logic [15:0] remain;
    logic        running;
    logic        done;
    logic        alarm;

    int nvec = 0;
    int nerr = 0;
    int done_cnt = 0;

    typedef struct {
        logic [15:0] num;
        logic [15:0] rem;
        logic        run;
    } vec_t;

    typedef struct {
        logic [15:0] rem;
        logic        run;
    } exp_t;

    exp_t exp_q[$];
    vec_t vecs[6];

    service_2_countdown #(.TICK_DIV(4)) dut (
        .clk    (clk),
        .reset  (reset),
        .load   (load),
        .num_in (num_in),
        .push_c (push_c),
        .remain (remain),
        .running(running),
        .done   (done),
        .alarm  (alarm)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_load(input logic [15:0] v);
        load = 1'b1;
        num_in = v;
        cyc(1);
        load = 1'b0;
    endtask

    task automatic pulse_push();
        push_c = 1'b1;
        cyc(1);
        push_c = 1'b0;
    endtask

    task automatic sb_check(input string name);
        exp_t e;
        if (exp_q.size() == 0) begin
            nvec++;
            nerr++;
            $display("FAIL %s: got empty scoreboard expected entry", name);
        end else begin
            e = exp_q.pop_front();
            chk({name, "_remain"}, 32'(remain), 32'(e.rem));
            chk({name, "_running"}, 32'(running), 32'(e.run));
        end
    endtask

    initial begin
        int d0;
        int stable;

        vecs[0] = '{16'hFA7C, 16'h9959, 1'b1};
        vecs[1] = '{16'h0000, 16'h0000, 1'b0};
        vecs[2] = '{16'h1234, 16'h1234, 1'b1};
        vecs[3] = '{16'h0960, 16'h0950, 1'b1};
        vecs[4] = '{16'h00AF, 16'h0059, 1'b1};
        vecs[5] = '{16'hB000, 16'h9000, 1'b1};

        // Reset state
        #12;
        chk("rst_remain", 32'(remain), 32'h0);
        chk("rst_running", 32'(running), 0);
        chk("rst_alarm", 32'(alarm), 0);
        chk("rst_done", 32'(done), 0);
        @(negedge clk);
        reset = 1'b1;
        cyc(1);

        // Load sanitising table; push_c afterwards reveals READY vs IDLE
        d0 = done_cnt;
        foreach (vecs[i]) begin
            exp_q.push_back('{vecs[i].rem, 1'b0});
            pulse_load(vecs[i].num);
            sb_check($sformatf("vec%0d_load", i));
            chk($sformatf("vec%0d_alarm", i), 32'(alarm), 0);
            exp_q.push_back('{vecs[i].rem, vecs[i].run});
            pulse_push();
            sb_check($sformatf("vec%0d_push", i));
        end
        chk("table_no_done", 32'(done_cnt - d0), 0);

        // Basic countdown 0003
        pulse_load(16'h0003);
        d0 = done_cnt;
        pulse_push();
        chk("cd_running", 32'(running), 1);
        cyc(3);
        chk("cd_hold3", 32'(remain), 32'h0003);
        cyc(1);
        chk("cd_t4", 32'(remain), 32'h0002);
        cyc(4);
        chk("cd_t8", 32'(remain), 32'h0001);
        cyc(4);
        chk("cd_t12", 32'(remain), 32'h0000);
        chk("cd_done", 32'(done), 1);
        chk("cd_alarm", 32'(alarm), 1);
        chk("cd_running_off", 32'(running), 0);
        cyc(3);
        chk("cd_done_once", 32'(done_cnt - d0), 1);
        chk("cd_frozen", 32'(remain), 32'h0000);
        chk("cd_alarm_level", 32'(alarm), 1);
        pulse_push();
        chk("cd_ack_alarm", 32'(alarm), 0);

        // BCD borrow
        pulse_load(16'h1000);
        pulse_push();
        cyc(4);
        chk("borrow_1000", 32'(remain), 32'h0959);
        pulse_load(16'h0100);
        pulse_push();
        cyc(4);
        chk("borrow_0100", 32'(remain), 32'h0059);

        // Pause / resume keeps the prescaler
        pulse_load(16'h0010);
        pulse_push();
        cyc(1);
        pulse_push();
        chk("pause_running", 32'(running), 0);
        stable = 1;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            if (remain !== 16'h0010) stable = 0;
        end
        chk("pause_stable", 32'(stable), 1);
        pulse_push();
        chk("resume_running", 32'(running), 1);
        cyc(1);
        chk("resume_plus1", 32'(remain), 32'h0010);
        cyc(1);
        chk("resume_plus2", 32'(remain), 32'h0009);

        // Tick coinciding with push_c: decrement then pause; last tick wins over push_c
        pulse_load(16'h0002);
        d0 = done_cnt;
        pulse_push();
        cyc(3);
        pulse_push();
        chk("coin_dec", 32'(remain), 32'h0001);
        chk("coin_paused", 32'(running), 0);
        cyc(5);
        chk("coin_hold", 32'(remain), 32'h0001);
        pulse_push();
        cyc(3);
        pulse_push();
        chk("coin_zero", 32'(remain), 32'h0000);
        chk("coin_alarm", 32'(alarm), 1);
        cyc(1);
        chk("coin_done_once", 32'(done_cnt - d0), 1);
        chk("coin_still_done", 32'(alarm), 1);

        // Load and push_c together in RUN: load wins
        pulse_load(16'h0005);
        pulse_push();
        cyc(2);
        load = 1'b1;
        push_c = 1'b1;
        num_in = 16'h0042;
        cyc(1);
        load = 1'b0;
        push_c = 1'b0;
        chk("lp_remain", 32'(remain), 32'h0042);
        chk("lp_running", 32'(running), 0);
        cyc(10);
        chk("lp_ready_hold", 32'(remain), 32'h0042);
        pulse_push();
        chk("lp_ready_start", 32'(running), 1);

        // Asynchronous reset mid-RUN
        pulse_load(16'h0006);
        pulse_push();
        cyc(4);
        chk("rr_at5", 32'(remain), 32'h0005);
        d0 = done_cnt;
        #2;
        reset = 1'b0;
        #1;
        chk("rr_remain", 32'(remain), 32'h0000);
        chk("rr_running", 32'(running), 0);
        chk("rr_alarm", 32'(alarm), 0);
        cyc(3);
        @(negedge clk);
        reset = 1'b1;
        cyc(8);
        chk("rr_idle_remain", 32'(remain), 32'h0000);
        chk("rr_no_done", 32'(done_cnt - d0), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
